wb_exc_commit: RTL and testbench
================================

# wb_exc_commit

Write-back stage commit and exception controller of the LoongArch-32 five-stage pipeline. Holds the WB pipeline register fed by the MEM stage, resolves exception and interrupt priority for the instruction in WB, drives the CSR file's write, read, exception and ERTN interface, and issues the pipeline flush and redirect PC. It sits between the MEM stage and the register file and CSR file.

## Interface
- Parameters: none. Ecode/esubcode values come from csr.vh:
  - INT=0x00
  - ADE=0x08 (ADEF=0, ADEM=1)
  - ALE=0x09
  - SYS=0x0B
  - BRK=0x0C
  - INE=0x0D
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ms_valid  in  1  MEM stage offers an instruction.
- ws_allowin  out  1  WB accepts this cycle.
- ms_pc, ms_vaddr  in  32  PC and data address (used for ALE/ADEM).
- ms_exc  in  6  flags {ine, brk, sys, ale, adem, adef}.
- ms_ertn  in  1  instruction is ERTN.
- ms_csr_we, ms_csr_re  in  1  CSR write / CSR read.
- ms_csr_num  in  14  CSR number.
- ms_csr_wmask, ms_csr_wvalue  in  32  CSR write mask and value.
- ms_rf_we  in  1  register write enable; ms_dest  in  5  destination; ms_result  in  32  ALU/load result.
- has_int  in  1  pending enabled interrupt, from the CSR file.
- ex_entry, ex_epc  in  32  EENTRY and ERA, from the CSR file.
- csr_rvalue  in  32  CSR read data.
- csr_we, csr_re  out  1; csr_num  out  14; csr_wmask, csr_wvalue  out  32.
- wb_ex, ertn_flush  out  1; wb_ecode  out  6; wb_esubcode  out  9; wb_pc, wb_vaddr  out  32.
- flush  out  1  kill IF/ID/EX/MEM; flush_pc  out  32  redirect target.
- rf_we  out  1; rf_waddr  out  5; rf_wdata  out  32.
- inst_retired  out  32  count of committed instructions.

## Operation
- **WB register:** on ws_allowin && ms_valid, latch all ms_* fields and set ws_valid. On ws_allowin && !ms_valid, clear ws_valid.
- **States:**
  - RUN: ws_allowin=1.
  - DRAIN: ws_allowin=1, input is discarded, and ws_valid is cleared.
- **Transitions:**
  - RUN→DRAIN on the cycle flush=1.
  - DRAIN→RUN after exactly 1 cycle.
- **Exception priority** for a valid WB instruction, highest first:
  - has_int → INT / 0
  - adef → ADE / ADEF, wb_vaddr = ws_pc
  - ine → INE
  - sys → SYS
  - brk → BRK
  - ale → ALE, wb_vaddr = ws_vaddr
  - adem → ADE / ADEM, wb_vaddr = ws_vaddr
  - Esubcode is 0 except for ADEM.
- **wb_ex** = ws_valid && (has_int || |ws_exc) && state==RUN.
- **ertn_flush** = ws_valid && ws_ertn && !wb_ex && state==RUN.
- **flush** = wb_ex || ertn_flush. flush_pc = wb_ex ? ex_entry : ex_epc.
- **CSR side effects:** csr_we = ws_valid && ws_csr_we && !wb_ex. csr_re likewise. csr_num, csr_wmask and csr_wvalue pass through from the WB register.
- **Register write:**
  - rf_we = ws_valid && ws_rf_we && !wb_ex && state==RUN.
  - rf_wdata = ws_csr_re ? csr_rvalue : ws_result.
  - A write to r0 is still issued; the register file ignores it.
- **Retire counter:** inst_retired increments by 1 each cycle a ws_valid instruction completes without wb_ex. ERTN counts as retired. The counter wraps from 0xFFFFFFFF to 0.
- wb_pc = ws_pc whenever wb_ex=1.

## Timing
- **Reset values:**
  - ws_valid=0, state=RUN, inst_retired=0.
  - All outputs are 0 except ws_allowin=1.
  - Reset mid-DRAIN returns to RUN.
- **Latency:** one cycle from MEM accept to commit outputs, which are combinational from the WB register. CSR writes and exceptions take effect at the next edge inside the CSR file.
- **Flush:** asserted for exactly one cycle per exception or ERTN. The instruction offered by MEM in the flush cycle is dropped, and so is the one offered in the following DRAIN cycle.
- **Interrupt/exception vs. other effects:**
  - If has_int rises while the WB instruction also has a CSR write, the write is suppressed and INT is taken.
  - ERTN with a pending exception flag takes the exception; ertn_flush=0.
- DRAIN never produces wb_ex, ertn_flush, csr_we or rf_we, even if the register is stale.

## Test plan
- **Plain ALU instruction:** ms_valid=1, rf_we=1, dest=5, result=0x1234 → next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234, inst_retired=1, flush=0.
- **CSR read/write:** csrrd/csrwr with csr_num=0x30, wmask=0xFFFFFFFF, wvalue=0xA5, csr_rvalue=0x77 → csr_we=1, csr_re=1, rf_wdata=0x77.
- **Fetch address error:** adef=1 together with ale=1 at pc=0x1C000003 → wb_ex=1, wb_ecode=0x08, wb_esubcode=0, wb_vaddr=0x1C000003, flush_pc=ex_entry, rf_we=0. The next two MEM offers are dropped.
- **Load address error:** adem=1, vaddr=0x80000001 → wb_ecode=0x08, wb_esubcode=1, wb_vaddr=0x80000001.
- **Interrupt over CSR write:** has_int=1 on a CSR write → wb_ecode=0, csr_we=0, wb_pc=ws_pc, inst_retired unchanged.
- **ERTN, then reset:** ERTN with ex_epc=0x1C000100 → ertn_flush=1, flush_pc=0x1C000100, inst_retired+1. Asserting reset during DRAIN → all outputs 0, ws_allowin=1.

Source files
------------

// File: rtl/wb_exc_commit.sv
// wb_exc_commit
// Write-back stage of the LoongArch-32 five-stage pipeline. Holds the WB
// pipeline register, resolves exception/interrupt priority for the
// instruction in WB, drives the CSR file's write/read/exception/ERTN
// interface, commits to the register file and issues the pipeline flush.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   ms_valid / ws_allowin      MEM->WB handshake (WB always accepts)
//   ms_pc, ms_vaddr            instruction PC and data address
//   ms_exc                     {ine, brk, sys, ale, adem, adef}
//   ms_ertn                    instruction is ERTN
//   ms_csr_*                   CSR access fields
//   ms_rf_we/ms_dest/ms_result register write-back fields
//   has_int, ex_entry, ex_epc  interrupt pending, EENTRY, ERA from CSR file
//   csr_rvalue                 CSR read data
//   csr_*                      CSR access to the CSR file
//   wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush
//                              exception / ERTN report to the CSR file
//   flush, flush_pc            kill IF..MEM and redirect
//   rf_we, rf_waddr, rf_wdata  register file write port
//   inst_retired               committed-instruction counter (wraps)
module wb_exc_commit (
    input  logic        clk,
    input  logic        reset,
    input  logic        ms_valid,
    output logic        ws_allowin,
    input  logic [31:0] ms_pc,
    input  logic [31:0] ms_vaddr,
    input  logic [5:0]  ms_exc,
    input  logic        ms_ertn,
    input  logic        ms_csr_we,
    input  logic        ms_csr_re,
    input  logic [13:0] ms_csr_num,
    input  logic [31:0] ms_csr_wmask,
    input  logic [31:0] ms_csr_wvalue,
    input  logic        ms_rf_we,
    input  logic [4:0]  ms_dest,
    input  logic [31:0] ms_result,
    input  logic        has_int,
    input  logic [31:0] ex_entry,
    input  logic [31:0] ex_epc,
    input  logic [31:0] csr_rvalue,
    output logic        csr_we,
    output logic        csr_re,
    output logic [13:0] csr_num,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic        ertn_flush,
    output logic [5:0]  wb_ecode,
    output logic [8:0]  wb_esubcode,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_vaddr,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] inst_retired
);

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [8:0] ESUB_ADEM = 9'd1;

    localparam int EXC_ADEF = 0;
    localparam int EXC_ADEM = 1;
    localparam int EXC_ALE  = 2;
    localparam int EXC_SYS  = 3;
    localparam int EXC_BRK  = 4;
    localparam int EXC_INE  = 5;

    typedef enum logic [0:0] {RUN, DRAIN} state_t;

    state_t      state_q, state_d;
    logic        ws_valid_q, ws_valid_d;
    logic [31:0] retired_q, retired_d;

    logic [31:0] ws_pc_q, ws_vaddr_q, ws_csr_wmask_q, ws_csr_wvalue_q, ws_result_q;
    logic [5:0]  ws_exc_q;
    logic        ws_ertn_q, ws_csr_we_q, ws_csr_re_q, ws_rf_we_q;
    logic [13:0] ws_csr_num_q;
    logic [4:0]  ws_dest_q;

    logic run, accept, commit;

    assign ws_allowin = 1'b1;
    assign run        = (state_q == RUN);

    // An offer is taken only in RUN and not in the flush cycle; the flush
    // cycle's offer and the DRAIN cycle's offer are both younger than the
    // faulting/ERTN instruction and must be discarded.
    assign accept = run && !flush && ms_valid;

    assign wb_ex      = ws_valid_q && (has_int || (|ws_exc_q)) && run;
    assign ertn_flush = ws_valid_q && ws_ertn_q && !wb_ex && run;
    assign flush      = wb_ex || ertn_flush;
    assign flush_pc   = wb_ex ? ex_entry : (ertn_flush ? ex_epc : 32'h0);
    assign commit     = ws_valid_q && !wb_ex && run;

    assign csr_we     = commit && ws_csr_we_q;
    assign csr_re     = commit && ws_csr_re_q;
    assign csr_num    = ws_valid_q ? ws_csr_num_q    : 14'h0;
    assign csr_wmask  = ws_valid_q ? ws_csr_wmask_q  : 32'h0;
    assign csr_wvalue = ws_valid_q ? ws_csr_wvalue_q : 32'h0;

    // r0 writes are issued as-is; the register file discards them.
    assign rf_we    = commit && ws_rf_we_q;
    assign rf_waddr = ws_valid_q ? ws_dest_q : 5'h0;
    assign rf_wdata = !ws_valid_q ? 32'h0 : (ws_csr_re_q ? csr_rvalue : ws_result_q);

    assign wb_pc        = ws_valid_q ? ws_pc_q : 32'h0;
    assign inst_retired = retired_q;

    always_comb begin
        wb_ecode    = 6'h0;
        wb_esubcode = 9'h0;
        wb_vaddr    = 32'h0;
        if (wb_ex) begin
            if (has_int) begin
                wb_ecode = ECODE_INT;
            end else if (ws_exc_q[EXC_ADEF]) begin
                wb_ecode = ECODE_ADE;
                wb_vaddr = ws_pc_q;
            end else if (ws_exc_q[EXC_INE]) begin
                wb_ecode = ECODE_INE;
            end else if (ws_exc_q[EXC_SYS]) begin
                wb_ecode = ECODE_SYS;
            end else if (ws_exc_q[EXC_BRK]) begin
                wb_ecode = ECODE_BRK;
            end else if (ws_exc_q[EXC_ALE]) begin
                wb_ecode = ECODE_ALE;
                wb_vaddr = ws_vaddr_q;
            end else begin
                wb_ecode    = ECODE_ADE;
                wb_esubcode = ESUB_ADEM;
                wb_vaddr    = ws_vaddr_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        ws_valid_d = accept;
        retired_d  = retired_q + {31'h0, commit};
        case (state_q)
            RUN:     if (flush) state_d = DRAIN;
            DRAIN:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            ws_valid_q <= 1'b0;
            retired_q  <= 32'h0;
        end else begin
            state_q    <= state_d;
            ws_valid_q <= ws_valid_d;
            retired_q  <= retired_d;
        end
    end

    // WB data register: qualified by ws_valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ws_pc_q         <= ms_pc;
            ws_vaddr_q      <= ms_vaddr;
            ws_exc_q        <= ms_exc;
            ws_ertn_q       <= ms_ertn;
            ws_csr_we_q     <= ms_csr_we;
            ws_csr_re_q     <= ms_csr_re;
            ws_csr_num_q    <= ms_csr_num;
            ws_csr_wmask_q  <= ms_csr_wmask;
            ws_csr_wvalue_q <= ms_csr_wvalue;
            ws_rf_we_q      <= ms_rf_we;
            ws_dest_q       <= ms_dest;
            ws_result_q     <= ms_result;
        end
    end

endmodule

// File: tb/tb_wb_exc_commit.sv
module tb_wb_exc_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        ms_valid;
    logic        ws_allowin;
    logic [31:0] ms_pc, ms_vaddr;
    logic [5:0]  ms_exc;
    logic        ms_ertn, ms_csr_we, ms_csr_re;
    logic [13:0] ms_csr_num;
    logic [31:0] ms_csr_wmask, ms_csr_wvalue;
    logic        ms_rf_we;
    logic [4:0]  ms_dest;
    logic [31:0] ms_result;
    logic        has_int;
    logic [31:0] ex_entry, ex_epc, csr_rvalue;
    logic        csr_we, csr_re;
    logic [13:0] csr_num;
    logic [31:0] csr_wmask, csr_wvalue;
    logic        wb_ex, ertn_flush;
    logic [5:0]  wb_ecode;
    logic [8:0]  wb_esubcode;
    logic [31:0] wb_pc, wb_vaddr;
    logic        flush;
    logic [31:0] flush_pc;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] inst_retired;

    int checks = 0;
    int failures = 0;

    // exc flag bits {ine, brk, sys, ale, adem, adef}
    localparam logic [5:0] F_ADEF = 6'b000001;
    localparam logic [5:0] F_ADEM = 6'b000010;
    localparam logic [5:0] F_ALE  = 6'b000100;
    localparam logic [5:0] F_SYS  = 6'b001000;
    localparam logic [5:0] F_BRK  = 6'b010000;
    localparam logic [5:0] F_INE  = 6'b100000;

    always #5 clk = ~clk;

    wb_exc_commit dut (
        .clk(clk), .reset(reset), .ms_valid(ms_valid), .ws_allowin(ws_allowin),
        .ms_pc(ms_pc), .ms_vaddr(ms_vaddr), .ms_exc(ms_exc), .ms_ertn(ms_ertn),
        .ms_csr_we(ms_csr_we), .ms_csr_re(ms_csr_re), .ms_csr_num(ms_csr_num),
        .ms_csr_wmask(ms_csr_wmask), .ms_csr_wvalue(ms_csr_wvalue),
        .ms_rf_we(ms_rf_we), .ms_dest(ms_dest), .ms_result(ms_result),
        .has_int(has_int), .ex_entry(ex_entry), .ex_epc(ex_epc), .csr_rvalue(csr_rvalue),
        .csr_we(csr_we), .csr_re(csr_re), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_ecode(wb_ecode),
        .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
        .flush(flush), .flush_pc(flush_pc),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .inst_retired(inst_retired)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic clr_ms();
        ms_valid = 0; ms_pc = 0; ms_vaddr = 0; ms_exc = 0; ms_ertn = 0;
        ms_csr_we = 0; ms_csr_re = 0; ms_csr_num = 0; ms_csr_wmask = 0;
        ms_csr_wvalue = 0; ms_rf_we = 0; ms_dest = 0; ms_result = 0;
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge,
    // outputs are checked 2 time units after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_ms();
        reset = 1; has_int = 0; csr_rvalue = 0;
        ex_entry = 32'h1C00_8000; ex_epc = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_allowin", {31'h0, ws_allowin}, 32'h1);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        chk("rst_flush_pc", flush_pc, 32'h0);
        chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
        chk("rst_retired", inst_retired, 32'h0);
        reset = 0;

        // plain ALU instruction
        tick();
        clr_ms(); ms_valid = 1; ms_rf_we = 1; ms_dest = 5; ms_result = 32'h1234;
        tick(); ms_valid = 0; #1;
        chk("alu_rf_we", {31'h0, rf_we}, 32'h1);
        chk("alu_waddr", {27'h0, rf_waddr}, 32'd5);
        chk("alu_wdata", rf_wdata, 32'h1234);
        chk("alu_flush", {31'h0, flush}, 32'h0);
        tick(); #1;
        chk("alu_retired", inst_retired, 32'd1);
        chk("alu_idle_rf_we", {31'h0, rf_we}, 32'h0);

        // CSR read/write
        clr_ms(); ms_valid = 1; ms_csr_we = 1; ms_csr_re = 1; ms_csr_num = 14'h30;
        ms_csr_wmask = 32'hFFFF_FFFF; ms_csr_wvalue = 32'hA5; ms_rf_we = 1; ms_dest = 4;
        csr_rvalue = 32'h77;
        tick(); ms_valid = 0; #1;
        chk("csr_we", {31'h0, csr_we}, 32'h1);
        chk("csr_re", {31'h0, csr_re}, 32'h1);
        chk("csr_num", {18'h0, csr_num}, 32'h30);
        chk("csr_wmask", csr_wmask, 32'hFFFF_FFFF);
        chk("csr_wvalue", csr_wvalue, 32'hA5);
        chk("csr_rf_wdata", rf_wdata, 32'h77);
        tick(); #1;
        chk("csr_retired", inst_retired, 32'd2);

        // fetch address error beats ALE; next two offers are dropped
        clr_ms(); ms_valid = 1; ms_exc = F_ADEF | F_ALE; ms_pc = 32'h1C00_0003;
        ms_vaddr = 32'h1234_5678; ms_rf_we = 1; ms_dest = 3;
        tick();
        clr_ms(); ms_valid = 1; ms_rf_we = 1; ms_dest = 7; ms_result = 32'hDEAD;
        #1;
        chk("adef_wb_ex", {31'h0, wb_ex}, 32'h1);
        chk("adef_ecode", {26'h0, wb_ecode}, 32'h08);
        chk("adef_esub", {23'h0, wb_esubcode}, 32'h0);
        chk("adef_vaddr", wb_vaddr, 32'h1C00_0003);
        chk("adef_pc", wb_pc, 32'h1C00_0003);
        chk("adef_flush", {31'h0, flush}, 32'h1);
        chk("adef_flush_pc", flush_pc, 32'h1C00_8000);
        chk("adef_rf_we", {31'h0, rf_we}, 32'h0);
        chk("adef_ertn", {31'h0, ertn_flush}, 32'h0);
        tick(); #1;
        chk("drain_flush", {31'h0, flush}, 32'h0);
        chk("drain_rf_we", {31'h0, rf_we}, 32'h0);
        chk("drain_wb_ex", {31'h0, wb_ex}, 32'h0);
        tick(); ms_valid = 0; #1;
        chk("drop2_rf_we", {31'h0, rf_we}, 32'h0);
        chk("adef_retired", inst_retired, 32'd2);

        // load address error
        clr_ms(); ms_valid = 1; ms_exc = F_ADEM; ms_pc = 32'h1C00_0010;
        ms_vaddr = 32'h8000_0001;
        tick(); ms_valid = 0; #1;
        chk("adem_wb_ex", {31'h0, wb_ex}, 32'h1);
        chk("adem_ecode", {26'h0, wb_ecode}, 32'h08);
        chk("adem_esub", {23'h0, wb_esubcode}, 32'h1);
        chk("adem_vaddr", wb_vaddr, 32'h8000_0001);
        tick(); tick();

        // ALE alone
        clr_ms(); ms_valid = 1; ms_exc = F_ALE; ms_vaddr = 32'h0000_0402;
        tick(); ms_valid = 0; #1;
        chk("ale_ecode", {26'h0, wb_ecode}, 32'h09);
        chk("ale_vaddr", wb_vaddr, 32'h0000_0402);
        tick(); tick();

        // INE over BRK and ADEM
        clr_ms(); ms_valid = 1; ms_exc = F_INE | F_BRK | F_ADEM;
        tick(); ms_valid = 0; #1;
        chk("ine_ecode", {26'h0, wb_ecode}, 32'h0D);
        chk("ine_esub", {23'h0, wb_esubcode}, 32'h0);
        tick(); tick();

        // ERTN carrying SYS and BRK: SYS taken, no ertn_flush
        clr_ms(); ms_valid = 1; ms_ertn = 1; ms_exc = F_SYS | F_BRK;
        ex_epc = 32'h1C00_0100;
        tick(); ms_valid = 0; #1;
        chk("ertnsys_ecode", {26'h0, wb_ecode}, 32'h0B);
        chk("ertnsys_ertn", {31'h0, ertn_flush}, 32'h0);
        chk("ertnsys_fpc", flush_pc, 32'h1C00_8000);
        tick(); tick();

        // BRK alone
        clr_ms(); ms_valid = 1; ms_exc = F_BRK;
        tick(); ms_valid = 0; #1;
        chk("brk_ecode", {26'h0, wb_ecode}, 32'h0C);
        tick(); tick();

        // interrupt over CSR write
        clr_ms(); ms_valid = 1; ms_csr_we = 1; ms_csr_num = 14'h5; ms_pc = 32'h1C00_0020;
        ms_rf_we = 1;
        tick(); ms_valid = 0; has_int = 1; #1;
        chk("int_wb_ex", {31'h0, wb_ex}, 32'h1);
        chk("int_ecode", {26'h0, wb_ecode}, 32'h00);
        chk("int_csr_we", {31'h0, csr_we}, 32'h0);
        chk("int_rf_we", {31'h0, rf_we}, 32'h0);
        chk("int_pc", wb_pc, 32'h1C00_0020);
        chk("int_flush_pc", flush_pc, 32'h1C00_8000);
        tick(); has_int = 0; #1;
        chk("int_retired", inst_retired, 32'd2);
        tick();

        // ERTN, then reset during DRAIN
        clr_ms(); ms_valid = 1; ms_ertn = 1; ms_pc = 32'h1C00_0040;
        tick(); ms_valid = 0; #1;
        chk("ertn_flush", {31'h0, ertn_flush}, 32'h1);
        chk("ertn_wb_ex", {31'h0, wb_ex}, 32'h0);
        chk("ertn_flush_out", {31'h0, flush}, 32'h1);
        chk("ertn_flush_pc", flush_pc, 32'h1C00_0100);
        tick(); #1;
        chk("ertn_retired", inst_retired, 32'd3);
        reset = 1; #1;
        chk("rstd_allowin", {31'h0, ws_allowin}, 32'h1);
        chk("rstd_retired", inst_retired, 32'h0);
        chk("rstd_flush", {31'h0, flush}, 32'h0);
        chk("rstd_flush_pc", flush_pc, 32'h0);
        chk("rstd_wb_pc", wb_pc, 32'h0);
        chk("rstd_rf_wdata", rf_wdata, 32'h0);
        tick(); reset = 0;

        // back in RUN: an offer is accepted normally
        clr_ms(); ms_valid = 1; ms_rf_we = 1; ms_dest = 9; ms_result = 32'hCAFE;
        tick(); ms_valid = 0; #1;
        chk("post_rst_rf_we", {31'h0, rf_we}, 32'h1);
        chk("post_rst_wdata", rf_wdata, 32'hCAFE);
        tick(); #1;
        chk("post_rst_retired", inst_retired, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
